// File: rtl/result_bcd_converter.sv
// Binary result to packed-BCD converter (shift-and-add-3); optional two's complement input via BCD_SIGN_EN.
// Latency 2*width+1 edges from acceptance to done_o; valid_i is ignored while busy or while done_o is high.
module result_bcd_converter #(
    parameter int width  = 8,
    parameter int digits = 5
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    input  logic [2*width-1:0]    data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*digits-1:0]   bcd_o,
    output logic                  sign_o
);
    localparam int DW = 2 * width;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              r_state;
    logic [DW-1:0]       r_bin;
    logic [4*digits-1:0] r_scr;
    logic [CW-1:0]       r_cnt;
    logic                r_sign;

    logic                w_neg;
    logic [DW-1:0]       w_mag;
    logic [4*digits-1:0] w_adj;

`ifdef BCD_SIGN_EN
    // Negating the most negative value wraps to itself, which reads correctly as unsigned.
    assign w_neg = data_i[DW-1];
    assign w_mag = w_neg ? (~data_i + DW'(1)) : data_i;
`else
    assign w_neg = 1'b0;
    assign w_mag = data_i;
`endif

    always_comb begin
        w_adj = r_scr;
        for (int d = 0; d < digits; d++) begin
            if (r_scr[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            bcd_o   <= '0;
            sign_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A strobe overlapping the done pulse belongs to the finished result.
                    if (valid_i && !done_o) begin
                        r_bin   <= w_mag;
                        r_scr   <= '0;
                        r_cnt   <= CW'(DW);
                        r_sign  <= w_neg;
                        busy_o  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_scr, r_bin} <= {w_adj, r_bin} << 1;
                    r_cnt          <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_state <= DONE;
                end
                DONE: begin
                    bcd_o   <= r_scr;
                    sign_o  <= r_sign;
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: vector table, random values against a decimal model, corner sequences.
module tb_result_bcd_converter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [15:0] data;
    logic        busy_o;
    logic        done_o;
    logic [19:0] bcd_o;
    logic        sign_o;

    int tests  = 0;
    int failed = 0;

    result_bcd_converter #(.width(8), .digits(5)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .valid_i (valid),
        .data_i  (data),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o),
        .sign_o  (sign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [19:0] bcd;
        logic        sgn;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal digits by repeated division; sign handling from the two's complement rule.
    function automatic void model(input logic [15:0] d, output logic [19:0] b, output logic s);
        int unsigned v;
        s = 1'b0;
        v = 32'(d);
`ifdef BCD_SIGN_EN
        if (d[15]) begin
            s = 1'b1;
            v = 32'd65536 - 32'(d);
        end
`endif
        b = '0;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts d at edge 0, scrambles data_i afterwards, returns edges to done and busy violations.
    task automatic convert(input logic [15:0] d, output int lat, output logic [19:0] b,
                           output logic s, output int busy_bad);
        valid = 1'b1;
        data  = d;
        tick();
        valid    = 1'b0;
        data     = 16'($urandom);
        lat      = 0;
        busy_bad = 0;
        while (!done_o && lat < 40) begin
            if (!busy_o) busy_bad++;
            tick();
            lat++;
            data = 16'($urandom);
        end
        if (busy_o) busy_bad++;
        b = bcd_o;
        s = sign_o;
        tick();
    endtask

    vec_t        vecs[$];
    int          lat, bb, ndone, done_edge;
    logic [19:0] b, eb, held;
    logic        s, es;

    initial begin
        rst_n = 1'b0;
        valid = 1'b1;
        data  = 16'h1234;
        tick();
        tick();
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_bcd",  32'(bcd_o),  32'd0);
        check("reset_sign", 32'(sign_o), 32'd0);
        valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy_o), 32'd0);

        vecs.push_back('{16'h00FF, 20'h00255, 1'b0});
        vecs.push_back('{16'h03E8, 20'h01000, 1'b0});
        vecs.push_back('{16'h0000, 20'h00000, 1'b0});
        vecs.push_back('{16'h0009, 20'h00009, 1'b0});
        vecs.push_back('{16'h000A, 20'h00010, 1'b0});
        vecs.push_back('{16'h270F, 20'h09999, 1'b0});
        vecs.push_back('{16'h2710, 20'h10000, 1'b0});
`ifdef BCD_SIGN_EN
        vecs.push_back('{16'hFFFF, 20'h00001, 1'b1});
        vecs.push_back('{16'hFFAB, 20'h00085, 1'b1});
        vecs.push_back('{16'h8000, 20'h32768, 1'b1});
        vecs.push_back('{16'h7FFF, 20'h32767, 1'b0});
`else
        vecs.push_back('{16'hFFFF, 20'h65535, 1'b0});
        vecs.push_back('{16'h8000, 20'h32768, 1'b0});
`endif
        foreach (vecs[i]) begin
            convert(vecs[i].d, lat, b, s, bb);
            check($sformatf("vec%0d_bcd", i),  32'(b),   32'(vecs[i].bcd));
            check($sformatf("vec%0d_sign", i), 32'(s),   32'(vecs[i].sgn));
            check($sformatf("vec%0d_lat", i),  32'(lat), 32'd17);
            check($sformatf("vec%0d_busy", i), 32'(bb),  32'd0);
        end

        // Results hold while idle with data_i wiggling.
        held = bcd_o;
        for (int i = 0; i < 5; i++) begin
            data = 16'($urandom);
            tick();
        end
        check("hold_bcd", 32'(bcd_o), 32'(held));

        for (int n = 0; n < 40; n++) begin
            logic [15:0] rd;
            rd = 16'($urandom);
            model(rd, eb, es);
            convert(rd, lat, b, s, bb);
            check($sformatf("rand%0d_bcd", n), 32'(b), 32'(eb));
            check($sformatf("rand%0d_sign", n), 32'(s), 32'(es));
            check($sformatf("rand%0d_lat", n), 32'(lat), 32'd17);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
        end

        // Strobes mid-SHIFT and coincident with done_o are both dropped.
        valid = 1'b1;
        data  = 16'h0001;
        tick();
        valid = 1'b0;
        ndone = 0;
        done_edge = 0;
        b = '0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (done_o) begin
                ndone++;
                done_edge = e;
                b = bcd_o;
            end
            valid = (e == 4) || done_o;
            data  = 16'h0999;
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_edge",  32'(done_edge), 32'd17);
        check("ign_bcd",   32'(b), 32'h00001);
        check("ign_idle",  32'(busy_o), 32'd0);

        // Reset at edge 8 aborts the conversion.
        valid = 1'b1;
        data  = 16'h1234;
        tick();
        valid = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_bcd",  32'(bcd_o),  32'd0);
        check("abort_sign", 32'(sign_o), 32'd0);
        ndone = 0;
        for (int e = 0; e < 30; e++) begin
            if (done_o) ndone++;
            tick();
        end
        check("abort_nodone", 32'(ndone), 32'd0);
        convert(16'h0000, lat, b, s, bb);
        check("post_bcd", 32'(b),   32'd0);
        check("post_lat", 32'(lat), 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 Parameter: width, default 8, operand width of the upstream calculator; result width is 2*width.
REQ-002 Parameter: digits, default 5, number of BCD output digits; SHALL satisfy 10^digits > 2^(2*width)-1.
REQ-003 clock_i  input  1  single clock; all state changes on rising edge.
REQ-004 reset_i  input  1  synchronous, active-low reset.
REQ-005 valid_i  input  1  result-ready strobe, driven by the calculator's signal_o.
REQ-006 data_i  input  2*width  calculator result, driven by the calculator's s_o.
REQ-007 busy_o  output  1  high while a conversion is in progress.
REQ-008 done_o  output  1  one-cycle pulse when bcd_o is updated.
REQ-009 bcd_o  output  4*digits  packed BCD; digit 0 in bits [3:0].
REQ-010 sign_o  output  1  result sign, 1 = negative (see REQ-026).

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 IDLE: on an edge with valid_i=1, the block SHALL capture data_i into the binary shift register, clear the BCD scratch register, load the bit counter with 2*width, and enter SHIFT.
REQ-013 IDLE with valid_i=0: the block SHALL stay in IDLE, and all outputs SHALL hold.
REQ-014 SHIFT, each edge: the block SHALL add 3 to every scratch digit >= 5, then shift {scratch, binary} left by 1 and decrement the counter.
REQ-015 SHIFT: on the edge that performs the final (2*width-th) shift, the block SHALL enter DONE.
REQ-016 DONE: on the next edge, the block SHALL load bcd_o from scratch, assert done_o for exactly one cycle, and return to IDLE.
REQ-017 Latency: if valid_i is sampled at edge 0, bcd_o and done_o SHALL update at edge 2*width+1 (17 edges for width=8).
REQ-018 busy_o SHALL be 1 from edge 0 through edge 2*width, and 0 in the cycle done_o is high.
REQ-019 valid_i asserted outside IDLE (SHIFT or DONE) SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-020 A valid_i pulse coincident with done_o SHALL be ignored; the earliest acceptance is the edge after done_o falls.
REQ-021 bcd_o and sign_o SHALL hold their last result until the next done_o.
REQ-022 data_i SHALL be sampled only at acceptance; later changes on data_i SHALL have no effect.
REQ-023 Every bcd_o digit SHALL be in the range 0..9 whenever done_o=1.

Reset
REQ-024 With reset_i=0 at an edge: state=IDLE; busy_o=0; done_o=0; sign_o=0; bcd_o=0; scratch, shift register and counter cleared.
REQ-025 Reset SHALL take priority over valid_i and SHALL abort a conversion mid-SHIFT or in DONE; no done_o SHALL follow the abort.

Configuration
REQ-026 Macro BCD_SIGN_EN defined: at acceptance, the block SHALL treat data_i as two's complement; sign_o SHALL take data_i MSB at done_o; the magnitude (-data_i if negative) SHALL be converted; 0x8000 SHALL give magnitude 32768.
REQ-027 Macro BCD_SIGN_EN undefined: data_i SHALL be unsigned, and sign_o SHALL be constant 0.

Verification
REQ-028 valid_i=1 for 1 cycle with data_i=16'h00FF (0xAA+0x55) -> bcd_o=20'h00255 and done_o pulse at edge 17; busy_o high for edges 0..16.
REQ-029 data_i=16'h03E8 (5*200) -> bcd_o=20'h01000; then data_i=16'hFFFF without BCD_SIGN_EN -> bcd_o=20'h65535, sign_o=0.
REQ-030 data_i=16'hFFAB with BCD_SIGN_EN -> sign_o=1, bcd_o=20'h00085; data_i=16'h8000 -> sign_o=1, bcd_o=20'h32768.
REQ-031 Accept data_i=16'h0001, then pulse valid_i with 16'h0999 at edge 5 and at the done_o edge -> bcd_o=20'h00001, exactly one done_o, block IDLE afterwards.
REQ-032 Accept 16'h1234, drive reset_i=0 at edge 8 for 1 cycle -> all outputs 0 and no done_o; then 16'h0000 -> bcd_o=0 with a done_o pulse 17 edges after acceptance.
